// File: rtl/uram_port_ctrl.sv
// Front end for a single-port no-change UltraRAM: issues at most one access per cycle,
// tracks reads through the fixed URAM read pipeline and lands them in a credit-guarded FIFO.
module uram_port_ctrl #(
  parameter int AWIDTH    = 12,
  parameter int NUM_COL   = 9,
  parameter int CWIDTH    = 8,
  parameter int DWIDTH    = 72,
  parameter int NBPIPE    = 3,
  parameter int RSP_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AWIDTH-1:0]  req_addr,
  input  logic [DWIDTH-1:0]  req_wdata,
  input  logic [NUM_COL-1:0] req_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DWIDTH-1:0]  rsp_rdata,
  output logic               ram_mem_en,
  output logic [NUM_COL-1:0] ram_we,
  output logic               ram_regce,
  output logic [AWIDTH-1:0]  ram_addr,
  output logic [DWIDTH-1:0]  ram_din,
  input  logic [DWIDTH-1:0]  ram_dout,
  output logic               busy
);

  localparam int L  = NBPIPE + 2;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

  logic              fire;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;
  logic [L-1:0]      rd_tok_reg, rd_tok_next;
  logic [CW-1:0]     inflight_reg, inflight_next;
  logic [CW-1:0]     occ_reg, occ_next;
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [DWIDTH-1:0] fifo_mem [RSP_DEPTH];

  // Every accepted read already owns a FIFO slot, so the URAM pipe never needs to stall.
  assign credit_used = {1'b0, inflight_reg} + {1'b0, occ_reg};
  assign req_ready   = ~rst & (credit_used < DEPTH_C);
  assign fire        = req_valid & req_ready;
  assign rd_fire     = fire & ~req_write;

  assign ram_mem_en = fire;
  assign ram_regce  = 1'b1;
  assign ram_addr   = req_addr;

  generate
    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_lane
      assign ram_din[gi*CWIDTH +: CWIDTH] = req_wdata[gi*CWIDTH +: CWIDTH];
      assign ram_we[gi]                   = fire & req_write & req_wstrb[gi];
    end
  endgenerate

  assign push      = rd_tok_reg[L-1];
  assign rsp_valid = (occ_reg != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr_reg];
  assign busy      = (inflight_reg != '0) | (occ_reg != '0);

  always_comb begin
    rd_tok_next   = {rd_tok_reg[L-2:0], rd_fire};
    inflight_next = inflight_reg;
    occ_next      = occ_reg;
    if (rd_fire & ~push)
      inflight_next = inflight_reg + CW'(1);
    else if (~rd_fire & push)
      inflight_next = inflight_reg - CW'(1);
    if (push & ~pop)
      occ_next = occ_reg + CW'(1);
    else if (~push & pop)
      occ_next = occ_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tok_reg   <= '0;
      inflight_reg <= '0;
      occ_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      rd_tok_reg   <= rd_tok_next;
      inflight_reg <= inflight_next;
      occ_reg      <= occ_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Storage is left out of reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= ram_dout;
  end

endmodule

// File: tb/tb_uram_port_ctrl.sv
// Directed bench for uram_port_ctrl with a behavioural no-change URAM model and
// an in-order response scoreboard.
module tb_uram_port_ctrl;

  localparam int AW = 12;
  localparam int NC = 9;
  localparam int DW = 72;
  localparam int NBPIPE = 3;
  localparam int DEPTH = 8;
  localparam int L = NBPIPE + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NC-1:0] req_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_mem_en, ram_regce, busy;
  logic [NC-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  bit rnd_mode = 1'b0;
  logic [DW-1:0] cur_exp;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uram_port_ctrl #(
    .AWIDTH(AW), .NUM_COL(NC), .CWIDTH(8), .DWIDTH(DW), .NBPIPE(NBPIPE), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_mem_en(ram_mem_en), .ram_we(ram_we), .ram_regce(ram_regce),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  // URAM model: L output registers, dout only reloaded by non-writing accesses.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] pipe [L];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  initial for (int i = 0; i < L; i++) pipe[i] = '0;
  assign ram_dout = pipe[L-1];
  always @(posedge clk) begin
    if (ram_mem_en) begin
      for (int i = 0; i < NC; i++)
        if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
      if (ram_we == '0) pipe[0] <= mem[ram_addr];
    end
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected data enqueued on read fire, compared on each pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got %h expected no response", rsp_rdata);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          $display("rsp %0d data %h", resp_cnt, rsp_rdata);
          chk("rsp_data", rsp_rdata, e);
        end
      end
      if (req_valid && req_ready && !req_write) exp_q.push_back(cur_exp);
      if (dut.rd_tok_reg[L-1] && dut.occ_reg == 4'(DEPTH) && !(rsp_valid && rsp_ready)) begin
        errors++;
        $display("FAIL fifo_overflow: got push at occ %0d expected no push", dut.occ_reg);
      end
    end
  end

  function automatic logic [DW-1:0] dpat(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {9{b}};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [NC-1:0] strb, input logic [DW-1:0] exp);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    cur_exp = exp;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        chk("ram_mem_en", DW'(ram_mem_en), DW'(1'b1));
        chk("ram_we", DW'(ram_we), wr ? DW'(strb) : '0);
        chk("ram_addr", DW'(ram_addr), DW'(addr));
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int k = 0; k < 300 && busy; k++) begin
      rsp_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    rsp_ready = 1'b1;
    chk("drain_busy", DW'(busy), 0);
    chk("drain_queue", DW'(exp_q.size()), 0);
  endtask

  // Read with the port idle and FIFO empty; measures cycles until rsp_valid.
  task automatic lat_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int cyc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wstrb = '0; cur_exp = exp;
    @(negedge clk);
    chk("lat_req_ready", DW'(req_ready), 1);
    step();
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk("read_latency", DW'(cyc), DW'(NBPIPE + 3));
    step();
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NC-1:0] strb;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int idx, cyc, base, seen;

    tbl[0]  = '{1'b1, 12'h020, 72'h0,               9'h1FF, 72'h0};
    tbl[1]  = '{1'b1, 12'h020, {9{8'hFF}},          9'h001, 72'h0};
    tbl[2]  = '{1'b0, 12'h020, 72'h0,               9'h000, 72'hFF};
    tbl[3]  = '{1'b1, 12'h000, dpat(0),             9'h1FF, 72'h0};
    tbl[4]  = '{1'b0, 12'h000, 72'h0,               9'h000, dpat(0)};
    tbl[5]  = '{1'b1, 12'h001, dpat(1),             9'h1FF, 72'h0};
    tbl[6]  = '{1'b0, 12'h001, 72'h0,               9'h000, dpat(1)};
    tbl[7]  = '{1'b1, 12'h002, dpat(2),             9'h1FF, 72'h0};
    tbl[8]  = '{1'b0, 12'h002, 72'h0,               9'h000, dpat(2)};
    tbl[9]  = '{1'b1, 12'h003, dpat(3),             9'h1FF, 72'h0};
    tbl[10] = '{1'b0, 12'h003, 72'h0,               9'h000, dpat(3)};
    tbl[11] = '{1'b1, 12'h030, dpat(7),             9'h1FF, 72'h0};
    tbl[12] = '{1'b0, 12'h030, 72'h0,               9'h000, dpat(7)};
    tbl[13] = '{1'b1, 12'h030, dpat(9),             9'h000, 72'h0};
    tbl[14] = '{1'b0, 12'h030, 72'h0,               9'h000, dpat(7)};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1; cur_exp = '0;
    repeat (3) step();
    chk("rst_req_ready", DW'(req_ready), 0);
    chk("rst_rsp_valid", DW'(rsp_valid), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("idle_mem_en", DW'(ram_mem_en), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", DW'(req_ready), 1);

    // Write then read the same address on the next cycle; nominal latency.
    send(1'b1, 12'h010, {9{8'h5A}}, 9'h1FF, 72'h0);
    lat_read(12'h010, {9{8'h5A}});

    // Table run with random consumer backpressure.
    base = resp_cnt;
    rnd_mode = 1'b1;
    for (int i = 0; i < 15; i++)
      send(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].exp);
    drain();
    rnd_mode = 1'b0;
    chk("table_resp_count", DW'(resp_cnt - base), 7);

    // Consumer stalled: only DEPTH reads may be accepted out of 12 offered.
    base = resp_cnt;
    rsp_ready = 1'b0;
    idx = 0;
    for (cyc = 0; cyc < 20 && idx < 12; cyc++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'(idx % 4); cur_exp = dpat(idx % 4);
      @(negedge clk);
      if (req_ready) idx++;
      step();
    end
    chk("bp_accepted", DW'(idx), DW'(DEPTH));
    chk("bp_req_ready", DW'(req_ready), 0);
    chk("bp_busy", DW'(busy), 1);
    chk("bp_rsp_valid", DW'(rsp_valid), 1);
    rsp_ready = 1'b1;
    #1;
    chk("rdy_before_pop", DW'(req_ready), 0);
    step();
    chk("rdy_after_pop", DW'(req_ready), 1);
    for (cyc = 0; cyc < 100 && idx < 12; cyc++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'(idx % 4); cur_exp = dpat(idx % 4);
      @(negedge clk);
      if (req_ready) idx++;
      step();
    end
    chk("bp_total_accepted", DW'(idx), 12);
    drain();
    chk("bp_resp_count", DW'(resp_cnt - base), 12);

    // Reset with 3 reads in the URAM pipe and 2 queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 12'h010, 72'h0, 9'h0, {9{8'h5A}});
    req_valid = 1'b0;
    step(); step();
    chk("mid_busy", DW'(busy), 1);
    chk("mid_rsp_valid", DW'(rsp_valid), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_rsp_valid", DW'(rsp_valid), 0);
    chk("mid_rst_busy", DW'(busy), 0);
    chk("mid_rst_ready", DW'(req_ready), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      step();
    end
    chk("post_rst_no_rsp", DW'(seen), 0);
    lat_read(12'h010, {9{8'h5A}});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
